// File: rtl/word_packer.sv
// Collects W-bit host words, most-significant first, into one K-bit block
// and hands it to a key/data register with a single-cycle write strobe.
module word_packer #(
  parameter int K = 128,
  parameter int W = 32
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   clear_i,
  input  logic                   valid_i,
  input  logic [W-1:0]           word_i,
  output logic                   ready_o,
  output logic                   we_o,
  output logic [K-1:0]           writeData_o,
  output logic [$clog2(K/W):0]   count_o,
  output logic                   busy_o
);

  localparam int N  = K / W;
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [CW-1:0] FULL = CW'(N);

  typedef enum logic {FILL, EMIT} state_t;

  state_t        state, state_next;
  logic [K-1:0]  shreg, shreg_next, shifted;
  logic [CW-1:0] count_next;
  logic          we_next, busy_next;
  logic [K-1:0]  data_next;

  generate
    if (N == 1) begin : g_single
      assign shifted = word_i;
    end else begin : g_shift
      assign shifted = {shreg[K-W-1:0], word_i};
    end
  endgenerate

  assign ready_o = (state == FILL) && !clear_i;

  always_comb begin
    state_next = state;
    count_next = count_o;
    shreg_next = shreg;
    we_next    = 1'b0;
    data_next  = writeData_o;
    case (state)
      FILL: begin
        if (clear_i) begin
          count_next = '0;
          shreg_next = '0;
        end else if (valid_i) begin
          shreg_next = shifted;
          // The Nth word goes straight into the output register so the
          // strobe cycle presents the complete block.
          if (count_o == LAST) begin
            state_next = EMIT;
            count_next = FULL;
            we_next    = 1'b1;
            data_next  = shifted;
          end else begin
            count_next = count_o + 1'b1;
          end
        end
      end
      EMIT: begin
        state_next = FILL;
        count_next = '0;
      end
      default: state_next = FILL;
    endcase
    busy_next = (count_next != '0);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= FILL;
      count_o     <= '0;
      shreg       <= '0;
      we_o        <= 1'b0;
      writeData_o <= '0;
      busy_o      <= 1'b0;
    end else begin
      state       <= state_next;
      count_o     <= count_next;
      shreg       <= shreg_next;
      we_o        <= we_next;
      writeData_o <= data_next;
      busy_o      <= busy_next;
    end
  end

endmodule

// File: tb/tb_word_packer.sv
// Directed bench for word_packer: table-driven cycle vectors plus
// hand-written asynchronous-reset sequences.
module tb_word_packer;

  localparam int K  = 128;
  localparam int W  = 32;
  localparam int CW = 3;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          clear_i = 1'b0;
  logic          valid_i = 1'b0;
  logic [W-1:0]  word_i = '0;
  logic          ready_o;
  logic          we_o;
  logic [K-1:0]  writeData_o;
  logic [CW-1:0] count_o;
  logic          busy_o;

  int checks = 0;
  int errors = 0;

  word_packer #(.K(K), .W(W)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .clear_i     (clear_i),
    .valid_i     (valid_i),
    .word_i      (word_i),
    .ready_o     (ready_o),
    .we_o        (we_o),
    .writeData_o (writeData_o),
    .count_o     (count_o),
    .busy_o      (busy_o)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic          valid;
    logic          clear;
    logic [W-1:0]  word;
    logic          rdy;
    logic          we;
    logic [CW-1:0] cnt;
    logic          busy;
    logic [K-1:0]  data;
  } vec_t;

  vec_t         vecs[$];
  logic [K-1:0] cur_blk = '0;

  task automatic add(input logic v, input logic c, input logic [W-1:0] w,
                     input logic rdy, input logic we, input int cnt);
    vec_t r;
    r.valid = v;
    r.clear = c;
    r.word  = w;
    r.rdy   = rdy;
    r.we    = we;
    r.cnt   = CW'(cnt);
    r.busy  = (cnt != 0);
    r.data  = cur_blk;
    vecs.push_back(r);
  endtask

  task automatic chk(input string name, input logic [K-1:0] act, input logic [K-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [W-1:0] w);
    valid_i = 1'b1;
    clear_i = 1'b0;
    word_i  = w;
    @(posedge clock);
    #1;
    valid_i = 1'b0;
  endtask

  initial begin
    // Basic block
    add(1, 0, 32'h00112233, 1, 0, 1);
    add(1, 0, 32'h44556677, 1, 0, 2);
    add(1, 0, 32'h8899AABB, 1, 0, 3);
    cur_blk = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    add(1, 0, 32'hCCDDEEFF, 1, 1, 4);
    add(0, 0, 32'h0,        0, 0, 0);
    add(0, 0, 32'h0,        1, 0, 0);
    // Gapped: 0/3/1 idle cycles between words
    add(1, 0, 32'h00112233, 1, 0, 1);
    add(1, 0, 32'h44556677, 1, 0, 2);
    add(0, 0, 32'hFFFFFFFF, 1, 0, 2);
    add(0, 0, 32'hFFFFFFFF, 1, 0, 2);
    add(0, 0, 32'hFFFFFFFF, 1, 0, 2);
    add(1, 0, 32'h8899AABB, 1, 0, 3);
    add(0, 0, 32'h12345678, 1, 0, 3);
    add(1, 0, 32'hCCDDEEFF, 1, 1, 4);
    add(0, 0, 32'h0,        0, 0, 0);
    // Backpressure: valid held, word 4 presented during EMIT and retried
    add(1, 0, 32'hA0000000, 1, 0, 1);
    add(1, 0, 32'hA1111111, 1, 0, 2);
    add(1, 0, 32'hA2222222, 1, 0, 3);
    cur_blk = 128'hA0000000_A1111111_A2222222_A3333333;
    add(1, 0, 32'hA3333333, 1, 1, 4);
    add(1, 0, 32'hA4444444, 0, 0, 0);
    add(1, 0, 32'hA4444444, 1, 0, 1);
    add(1, 0, 32'hA5555555, 1, 0, 2);
    add(1, 0, 32'hA6666666, 1, 0, 3);
    cur_blk = 128'hA4444444_A5555555_A6666666_A7777777;
    add(1, 0, 32'hA7777777, 1, 1, 4);
    add(1, 0, 32'hA8888888, 0, 0, 0);
    // Clear mid-block wins over simultaneous valid
    add(1, 0, 32'hAAAAAAAA, 1, 0, 1);
    add(1, 0, 32'hBBBBBBBB, 1, 0, 2);
    add(1, 1, 32'hCCCCCCCC, 0, 0, 0);
    add(1, 0, 32'h00000001, 1, 0, 1);
    add(1, 0, 32'h00000002, 1, 0, 2);
    add(1, 0, 32'h00000003, 1, 0, 3);
    cur_blk = 128'h00000001_00000002_00000003_00000004;
    add(1, 0, 32'h00000004, 1, 1, 4);
    add(0, 0, 32'h0,        0, 0, 0);
    // Clear during EMIT is ignored; next block unaffected
    add(1, 0, 32'hDEADBEEF, 1, 0, 1);
    add(1, 0, 32'hCAFEF00D, 1, 0, 2);
    add(1, 0, 32'h01234567, 1, 0, 3);
    cur_blk = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
    add(1, 0, 32'h89ABCDEF, 1, 1, 4);
    add(1, 1, 32'h55555555, 0, 0, 0);
    add(1, 0, 32'h11111111, 1, 0, 1);
    add(1, 0, 32'h22222222, 1, 0, 2);
    add(1, 0, 32'h33333333, 1, 0, 3);
    cur_blk = 128'h11111111_22222222_33333333_44444444;
    add(1, 0, 32'h44444444, 1, 1, 4);
    add(0, 0, 32'h0,        0, 0, 0);

    // Reset state
    #2;
    chk("rst count", count_o, 0);
    chk("rst we", we_o, 0);
    chk("rst data", writeData_o, 0);
    chk("rst busy", busy_o, 0);
    #10 reset_n = 1'b1;
    #1;
    chk("rst ready", ready_o, 1);
    @(posedge clock);
    #1;

    foreach (vecs[i]) begin
      valid_i = vecs[i].valid;
      clear_i = vecs[i].clear;
      word_i  = vecs[i].word;
      #1;
      chk($sformatf("row%0d ready", i), ready_o, vecs[i].rdy);
      @(posedge clock);
      #1;
      chk($sformatf("row%0d we", i), we_o, vecs[i].we);
      chk($sformatf("row%0d count", i), count_o, vecs[i].cnt);
      chk($sformatf("row%0d busy", i), busy_o, vecs[i].busy);
      chk($sformatf("row%0d data", i), writeData_o, vecs[i].data);
    end
    valid_i = 1'b0;
    clear_i = 1'b0;

    // Reset between edges with 3 words held
    send(32'h0000AAAA);
    send(32'h0000BBBB);
    send(32'h0000CCCC);
    chk("pre-rst count", count_o, 3);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst count", count_o, 0);
    chk("midrst busy", busy_o, 0);
    chk("midrst we", we_o, 0);
    #2 reset_n = 1'b1;
    @(posedge clock);
    #1;
    chk("postrst we", we_o, 0);
    chk("postrst count", count_o, 0);
    chk("postrst ready", ready_o, 1);

    // Reset during EMIT
    send(32'h00000011);
    send(32'h00000022);
    send(32'h00000033);
    send(32'h00000044);
    chk("emit we", we_o, 1);
    chk("emit data", writeData_o, 128'h00000011_00000022_00000033_00000044);
    #2 reset_n = 1'b0;
    #1;
    chk("emitrst we", we_o, 0);
    chk("emitrst data", writeData_o, 0);
    chk("emitrst count", count_o, 0);
    #1 reset_n = 1'b1;
    @(posedge clock);
    #1;
    chk("emitrst after we", we_o, 0);
    chk("emitrst ready", ready_o, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
